// File: rtl/emmc_ddr_rx_deframer.sv
// eMMC DDR receive deframer: finds the start bit on DAT0, deserialises the
// rising- and falling-edge streams into 16-bit words, then checks the
// per-line/per-edge CRC16 and the end bit of one data block.
module emmc_ddr_rx_deframer #(
  parameter int unsigned          BLKSIZE_W      = 12,
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [1:0]           BusWidth,
  input  logic [BLKSIZE_W-1:0] BlockSize,
  input  logic [7:0]           DatPos,
  input  logic [7:0]           DatNeg,
  output logic [15:0]          DataOut,
  output logic                 DataValid,
  output logic                 Busy,
  output logic                 Done,
  output logic                 CrcError,
  output logic                 EndBitError,
  output logic                 Timeout
);

  localparam int BC_W = BLKSIZE_W + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
  } state_t;

  // CRC16 x^16+x^12+x^5+1, one data bit per call, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            width_q, width_d;      // 0=1-bit, 1=4-bit, 2=8-bit
  logic [BLKSIZE_W-1:0]  blksize_q, blksize_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;          // start timeout, then CRC bit count
  logic [2:0]            sub_q, sub_d;          // cycle within the current byte
  logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]            pos_sh_q, pos_sh_d, neg_sh_q, neg_sh_d;
  logic [15:0][15:0]     crc_q, crc_d;          // [7:0] rising lines, [15:8] falling lines
  logic [15:0][15:0]     rx_q, rx_d;            // received CRC, same layout
  logic [15:0]           dout_q, dout_d;
  logic                  dvalid_q, dvalid_d, busy_q, busy_d, done_q, done_d;
  logic                  crc_err_q, crc_err_d, end_err_q, end_err_d, tmo_q, tmo_d;

  logic [7:0]            lane_mask_s, pos_byte_s, neg_byte_s;
  logic [2:0]            sub_last_s;
  logic [BC_W-1:0]       byte_nxt_s;

  // Width-dependent decode: enabled lanes, cycles per byte, next byte images.
  always_comb begin
    lane_mask_s = 8'hFF;
    sub_last_s  = 3'd0;
    pos_byte_s  = DatPos;
    neg_byte_s  = DatNeg;
    byte_nxt_s  = byte_cnt_q + BC_W'(2);
    case (width_q)
      2'd0: begin
        lane_mask_s = 8'h01;
        sub_last_s  = 3'd7;
        pos_byte_s  = {pos_sh_q[6:0], DatPos[0]};
        neg_byte_s  = {neg_sh_q[6:0], DatNeg[0]};
      end
      2'd1: begin
        lane_mask_s = 8'h0F;
        sub_last_s  = 3'd1;
        pos_byte_s  = {pos_sh_q[3:0], DatPos[3:0]};
        neg_byte_s  = {neg_sh_q[3:0], DatNeg[3:0]};
      end
      default: begin
        lane_mask_s = 8'hFF;
        sub_last_s  = 3'd0;
        pos_byte_s  = DatPos;
        neg_byte_s  = DatNeg;
      end
    endcase
  end

  // Next-state and datapath logic; Abort overrides every state.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    blksize_d  = blksize_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    byte_cnt_d = byte_cnt_q;
    pos_sh_d   = pos_sh_q;
    neg_sh_d   = neg_sh_q;
    crc_d      = crc_q;
    rx_d       = rx_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_WAIT_START;
          width_d    = (BusWidth == 2'd3) ? 2'd2 : BusWidth;
          blksize_d  = BlockSize;
          cnt_d      = '0;
          crc_d      = '0;
          rx_d       = '0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_START: begin
        if (!DatPos[0] && !DatNeg[0]) begin
          state_d    = S_DATA;
          sub_d      = 3'd0;
          byte_cnt_d = '0;
        end else if (cnt_q == TIMEOUT_CYCLES - TIMEOUT_W'(1)) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_DATA: begin
        for (int i = 0; i < 8; i++) begin
          crc_d[i]     = crc16_step(crc_q[i], DatPos[i]);
          crc_d[i + 8] = crc16_step(crc_q[i + 8], DatNeg[i]);
        end
        pos_sh_d = pos_byte_s;
        neg_sh_d = neg_byte_s;
        if (sub_q == sub_last_s) begin
          sub_d      = 3'd0;
          dvalid_d   = 1'b1;
          dout_d     = {neg_byte_s, pos_byte_s};
          byte_cnt_d = byte_nxt_s;
          if (byte_nxt_s >= {3'b000, blksize_q}) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      S_CRC: begin
        for (int i = 0; i < 8; i++) begin
          rx_d[i]     = {rx_q[i][14:0], DatPos[i]};
          rx_d[i + 8] = {rx_q[i + 8][14:0], DatNeg[i]};
        end
        if (cnt_q == TIMEOUT_W'(15)) begin
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_END: begin
        for (int i = 0; i < 8; i++) begin
          if (lane_mask_s[i] && ((rx_q[i] != crc_q[i]) || (rx_q[i + 8] != crc_q[i + 8]))) begin
            crc_err_d = 1'b1;
          end else begin
            crc_err_d = crc_err_d;
          end
          if (lane_mask_s[i] && !(DatPos[i] && DatNeg[i])) begin
            end_err_d = 1'b1;
          end else begin
            end_err_d = end_err_d;
          end
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (Abort) begin
      state_d  = S_IDLE;
      dvalid_d = 1'b0;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      width_q    <= 2'd0;
      blksize_q  <= '0;
      cnt_q      <= '0;
      sub_q      <= 3'd0;
      byte_cnt_q <= '0;
      pos_sh_q   <= 8'h00;
      neg_sh_q   <= 8'h00;
      crc_q      <= '0;
      rx_q       <= '0;
      dout_q     <= 16'h0000;
      dvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      blksize_q  <= blksize_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      byte_cnt_q <= byte_cnt_d;
      pos_sh_q   <= pos_sh_d;
      neg_sh_q   <= neg_sh_d;
      crc_q      <= crc_d;
      rx_q       <= rx_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign DataOut     = dout_q;
  assign DataValid   = dvalid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign CrcError    = crc_err_q;
  assign EndBitError = end_err_q;
  assign Timeout     = tmo_q;

endmodule

// File: tb/tb_emmc_ddr_rx_deframer.sv
// Directed bench for emmc_ddr_rx_deframer: drives whole blocks on the
// negative clock edge and checks words, flags, latency and pulse timing.
module tb_emmc_ddr_rx_deframer;

  logic        Clk = 1'b0;
  logic        Reset_n, Start, Abort;
  logic [1:0]  BusWidth;
  logic [11:0] BlockSize;
  logic [7:0]  DatPos, DatNeg;
  logic [15:0] DataOut;
  logic        DataValid, Busy, Done, CrcError, EndBitError, Timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_count = 0;
  int done_count = 0;
  int last_dv_cyc = 0;
  int base_dv;
  logic [15:0] exp_q[$];
  logic [15:0] mon_w;
  logic [7:0]  blk[2048];

  emmc_ddr_rx_deframer #(
    .BLKSIZE_W(12), .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
    .BusWidth(BusWidth), .BlockSize(BlockSize), .DatPos(DatPos), .DatNeg(DatNeg),
    .DataOut(DataOut), .DataValid(DataValid), .Busy(Busy), .Done(Done),
    .CrcError(CrcError), .EndBitError(EndBitError), .Timeout(Timeout)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clk = ~Clk;

  // Cycle counter used for latency checks.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC16 (x^16+x^12+x^5+1), init 0, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Output monitor: every DataValid must match the next expected word.
  always @(negedge Clk) begin
    if (DataValid) begin
      dv_count++;
      last_dv_cyc = cyc;
      check("dv_has_expect", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_w = exp_q.pop_front();
        check("data_out", {16'd0, DataOut}, {16'd0, mon_w});
      end
    end
    if (Done) done_count++;
  end

  task automatic idle_bus();
    DatPos = 8'hFF;
    DatNeg = 8'hFF;
  endtask

  // One block. kind: 0 normal, 1 Abort at data cycle stop_at, 2 Reset_n at stop_at.
  task automatic run_block(input logic [1:0] bw, input int nbytes, input logic [7:0] flip_neg,
                           input logic [7:0] endbad_neg, input int kind, input int stop_at,
                           input logic exp_crc, input logic exp_end);
    int w, cpb, ncyc, dc, t0, dv0, done0;
    logic [15:0] crc_p[8];
    logic [15:0] crc_n[8];
    logic [7:0] pb, nb, cp, cn;
    logic stopped;
    w = (bw == 2'd0) ? 1 : (bw == 2'd1) ? 4 : 8;
    cpb = 8 / w;
    ncyc = nbytes * 4 / w;
    for (int l = 0; l < 8; l++) begin
      crc_p[l] = 16'h0000;
      crc_n[l] = 16'h0000;
    end
    dv0 = dv_count;
    done0 = done_count;
    stopped = 1'b0;
    dc = 0;
    @(negedge Clk);
    Start = 1'b1; BusWidth = bw; BlockSize = 12'(nbytes);
    @(negedge Clk);
    Start = 1'b0; BusWidth = ~bw; BlockSize = 12'd6;
    check("busy_armed", Busy, 1);
    DatPos = 8'h00; DatNeg = 8'h00;
    @(negedge Clk);
    t0 = cyc;
    for (int k = 0; k < nbytes / 2 && !stopped; k++) begin
      pb = blk[2 * k];
      nb = blk[2 * k + 1];
      for (int c = 0; c < cpb && !stopped; c++) begin
        if (kind != 0 && dc == stop_at) begin
          stopped = 1'b1;
        end else begin
          cp = 8'(pb >> (8 - w * (c + 1)));
          cn = 8'(nb >> (8 - w * (c + 1)));
          DatPos = 8'($urandom);
          DatNeg = 8'($urandom);
          for (int l = 0; l < w; l++) begin
            DatPos[l] = cp[l];
            DatNeg[l] = cn[l];
            crc_p[l] = crc_step(crc_p[l], cp[l]);
            crc_n[l] = crc_step(crc_n[l], cn[l]);
          end
          if (c == cpb - 1) exp_q.push_back({nb, pb});
          dc++;
          @(negedge Clk);
        end
      end
    end
    if (stopped) begin
      if (kind == 1) Abort = 1'b1;
      else Reset_n = 1'b0;
      @(negedge Clk);
      Abort = 1'b0;
      Reset_n = 1'b1;
      idle_bus();
      check("stop_busy", Busy, 0);
      check("stop_done", Done, 0);
      check("stop_dv", DataValid, 0);
      repeat (20) @(negedge Clk);
      #1;
      check("stop_no_done", done_count - done0, 0);
      check("stop_words", dv_count - dv0, stop_at / cpb);
      check("stop_queue_empty", exp_q.size(), 0);
    end else begin
      for (int b = 15; b >= 0; b--) begin
        DatPos = 8'($urandom);
        DatNeg = 8'($urandom);
        for (int l = 0; l < w; l++) begin
          DatPos[l] = crc_p[l][b];
          DatNeg[l] = crc_n[l][b] ^ (flip_neg[l] && (b == 0));
        end
        @(negedge Clk);
      end
      DatPos = 8'($urandom);
      DatNeg = 8'($urandom);
      for (int l = 0; l < w; l++) begin
        DatPos[l] = 1'b1;
        DatNeg[l] = ~endbad_neg[l];
      end
      check("busy_end", Busy, 1);
      @(negedge Clk);
      idle_bus();
      check("done_pulse", Done, 1);
      check("crc_error", CrcError, exp_crc);
      check("end_bit_error", EndBitError, exp_end);
      check("no_timeout", Timeout, 0);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check("done_single", Done, 0);
      check("busy_idle", Busy, 0);
      check("crc_error_sticky", CrcError, exp_crc);
      check("end_error_sticky", EndBitError, exp_end);
      check("dv_count", dv_count - dv0, nbytes / 2);
      check("dv_latency", last_dv_cyc - t0, ncyc);
      check("queue_empty", exp_q.size(), 0);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0;
    BusWidth = 2'd0; BlockSize = 12'd0;
    idle_bus();
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dv", DataValid, 0);
    check("rst_dout", DataOut, 0);
    check("rst_crc", CrcError, 0);
    check("rst_end", EndBitError, 0);
    check("rst_tmo", Timeout, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 8-bit, 4 bytes: words 0x0100 then 0x0302.
    blk[0] = 8'h00; blk[1] = 8'h01; blk[2] = 8'h02; blk[3] = 8'h03;
    run_block(2'd2, 4, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);

    // 4-bit, 2 bytes: word 0x3CA5.
    blk[0] = 8'hA5; blk[1] = 8'h3C;
    run_block(2'd1, 2, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);

    // 1-bit, 512 random bytes, CRC bit flipped on DAT0 falling stream.
    for (int i = 0; i < 512; i++) blk[i] = 8'($urandom_range(0, 255));
    run_block(2'd0, 512, 8'h01, 8'h00, 0, 0, 1'b1, 1'b0);

    // 8-bit, DAT5 end bit low on the falling edge.
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom_range(0, 255));
    run_block(2'd2, 8, 8'h00, 8'h20, 0, 0, 1'b0, 1'b1);

    // BusWidth=3 acts as 8-bit, minimum block.
    blk[0] = 8'h5A; blk[1] = 8'hC3;
    run_block(2'd3, 2, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);

    // 4-bit, CRC error on DAT2 falling stream.
    for (int i = 0; i < 6; i++) blk[i] = 8'($urandom_range(0, 255));
    run_block(2'd1, 6, 8'h04, 8'h00, 0, 0, 1'b1, 1'b0);

    // No start bit: Timeout/Done 16 cycles after entering WAIT_START.
    base_dv = dv_count;
    @(negedge Clk);
    Start = 1'b1; BusWidth = 2'd2; BlockSize = 12'd2;
    idle_bus();
    @(negedge Clk);
    Start = 1'b0;
    check("tmo_busy", Busy, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      check("tmo_early", {Timeout, Done}, 0);
    end
    @(negedge Clk);
    check("tmo_pulse", Timeout, 1);
    check("tmo_done", Done, 1);
    check("tmo_busy_fall", Busy, 0);
    @(negedge Clk);
    check("tmo_single", Timeout, 0);
    check("tmo_no_dv", dv_count - base_dv, 0);

    // Abort mid-DATA, then a clean block.
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom_range(0, 255));
    run_block(2'd2, 8, 8'h00, 8'h00, 1, 2, 1'b0, 1'b0);
    run_block(2'd2, 8, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);

    // Reset mid-DATA, then a clean block.
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom_range(0, 255));
    run_block(2'd1, 8, 8'h00, 8'h00, 2, 5, 1'b0, 1'b0);
    check("post_rst_crc", CrcError, 0);
    run_block(2'd0, 4, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/emmc_ddr_rx_deframer.md
Name: emmc_ddr_rx_deframer

Overview:
Downstream consumer of the per-line DDR input cells on the eMMC DAT[7:0] bus. It takes the rising-edge and falling-edge samples of each data line, waits for the start bit, and deserialises one data block into 16-bit words. It then checks the per-line, per-edge CRC16 and the end bit, and reports completion or error to the host-controller data path.

Parameters:
BLKSIZE_W, 12, width of BlockSize (max block 2048 bytes)
TIMEOUT_W, 24, width of the start-bit timeout counter
TIMEOUT_CYCLES, 24'hFFFFFF, Clk cycles allowed in WAIT_START before Timeout

Ports:
Clk  input  1  bus clock; one Clk cycle = one eMMC DDR bit period pair
Reset_n  input  1  synchronous, active-low reset
Start  input  1  single-cycle pulse; arms reception of one block
Abort  input  1  single-cycle pulse; returns to IDLE, no Done
BusWidth  input  2  0=1-bit (DAT0), 1=4-bit (DAT3:0), 2=8-bit (DAT7:0); 3 is treated as 8-bit
BlockSize  input  BLKSIZE_W  block length in bytes, even, nonzero
DatPos  input  8  rising-edge sample per line
DatNeg  input  8  falling-edge sample per line; same bus period as DatPos, later in time
DataOut  output  16  [7:0]=even byte (rising stream), [15:8]=odd byte (falling stream)
DataValid  output  1  one-cycle strobe; DataOut valid
Busy  output  1  high in any state except IDLE
Done  output  1  one-cycle pulse at block end, with or without error
CrcError  output  1  sticky until next Start; any enabled line/edge CRC mismatch
EndBitError  output  1  sticky until next Start; end bit not 1 on both edges of any enabled line
Timeout  output  1  one-cycle pulse; no start bit within TIMEOUT_CYCLES

Behaviour:
- Reset (Reset_n=0 at posedge Clk): state IDLE; all outputs 0; counters, shift registers and CRC registers cleared. Reset mid-block discards the block with no Done.
- BusWidth and BlockSize are latched on Start; changes while Busy are ignored.
- Start while Busy is ignored. Abort has priority over all other events in every state: next state IDLE, no Done, no DataValid.
- States:
  - IDLE: on Start go to WAIT_START, clear sticky flags and CRCs.
  - WAIT_START: the start bit is DatPos[0]=0 and DatNeg[0]=0 in the same cycle. On it, go to DATA on the next cycle. A timeout counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 without a start bit, pulse Timeout and Done and go to IDLE.
  - DATA: the rising stream and falling stream are independent SDR streams. For each enabled line, each edge bit is shifted MSB-first into that stream's byte.
    - 8-bit: one byte per edge per cycle, line n = bit n.
    - 4-bit: high nibble first, then low nibble, over 2 cycles.
    - 1-bit: 8 cycles.
    - DATA lasts BlockSize*4/W cycles, W=1/4/8.
    - DataValid is asserted the cycle after the cycle that completes both bytes, so latency is 1 cycle. Rate: one word every 1/2/8 cycles.
  - CRC: 16 cycles. For each enabled line and each edge, a CRC16 (x^16+x^12+x^5+1, init 0, MSB first) has run over that line's data bits of that edge. The received CRC bits shift into a compare register. A mismatch on any enabled line/edge sets CrcError.
  - END: 1 cycle. Each enabled line must show 1 on both edges; otherwise set EndBitError. Go to DONE.
  - DONE: pulse Done for 1 cycle, return to IDLE. The Start-to-Start minimum is therefore IDLE→WAIT_START with no gap.
- Disabled lines are ignored for start, data, CRC and end checks.
- No backpressure: the consumer must accept every DataValid.
- Boundary: minimum block BlockSize=2 with 8-bit gives 1 DATA cycle. Byte counter width BLKSIZE_W+3 bits; no wrap for legal BlockSize.

Test Plan:
- 8-bit, BlockSize=4: after start cycle, drive DatPos=0x00,0x02 and DatNeg=0x01,0x03, then correct CRCs and end bit 1 → DataValid twice with DataOut=0x0100 then 0x0302; Done=1; CrcError=0; EndBitError=0.
- 4-bit, BlockSize=2, byte0=0xA5 rising and byte1=0x3C falling (DatPos[3:0]=A then 5, DatNeg[3:0]=3 then C) → one DataValid 2 cycles after start+1 with DataOut=0x3CA5; CRCs match.
- 1-bit, BlockSize=512, random data with one CRC bit flipped on the falling stream of DAT0 → 256 DataValid strobes, Done=1, CrcError=1, EndBitError=0.
- 8-bit, DAT5 end bit driven 0 on the falling edge → Done=1, EndBitError=1, CrcError=0.
- TIMEOUT_CYCLES=16, no start bit → Timeout and Done pulse exactly 16 cycles after entering WAIT_START, Busy falls, DataValid never asserts.
- Abort mid-DATA and, separately, Reset_n=0 mid-DATA → next cycle IDLE, Busy=0, no Done. A new Start then receives a clean block correctly.
